jtag_dmi_master: RTL and testbench
==================================

// Module: jtag_dmi_master
// PURPOSE
//  JTAG host engine: the driving end of the tck/tms/tdi/tdo link that feeds the debug transport module.
//  Accepts DMI requests (op/addr/data) on a valid/ready port from on-chip test logic.
//  Generates TCK from sysclk and walks the TAP through the required IR and DR scans.
//  Returns the DMI result (status/data) on a valid/ready response port.
// PARAMETERS
//  ABITS        7   DMI address width; DR length DRW = ABITS+34
//  IRLEN        5   TAP instruction register length
//  IR_DMI       5'h11  IR value selecting the dmi register
//  TCK_DIV      4   sysclk cycles per TCK half-period (>=1)
//  IDLE_CYCLES  2   TCK cycles spent in Run-Test/Idle between the op scan and the result scan
// PORTS
//  sysclk       in   1       system clock
//  sys_reset_n  in   1       async reset, active-low
//  req_valid    in   1       DMI request valid
//  req_ready    out  1       request accepted when valid&&ready
//  req_op       in   2       0 nop, 1 read, 2 write
//  req_addr     in   ABITS   DMI address
//  req_data     in   32      write data
//  rsp_valid    out  1       response valid
//  rsp_ready    in   1       response consumed when valid&&ready
//  rsp_op       out  2       captured status: 0 ok, 2 failed, 3 busy
//  rsp_data     out  32      captured read data
//  tck,tms,tdi  out  1       JTAG drive
//  trst         out  1       TAP reset, active-high
//  tdo          in   1       JTAG return
// BEHAVIOUR
//  Reset (sys_reset_n=0, async): tck=0, tms=1, tdi=0, trst=1, req_ready=0, rsp_valid=0, rsp_op=0, rsp_data=0, FSM=TAP_RST.
//  TCK: each TCK period = 2*TCK_DIV sysclk cycles, low phase first; tms/tdi update in the sysclk edge that drives tck low.
//   tdo is sampled on the sysclk edge that drives tck high. tck is held low in IDLE (free-running only while a sequence runs).
//  TAP_RST: trst=1 for the first TCK; 5 TCKs with tms=1; then 1 TCK with tms=0 (Run-Test/Idle).
//  IR_SCAN: tms 1,1,0,0 -> Shift-IR; shift IR_DMI LSB first over IRLEN TCKs, tms=1 on the last bit; then tms 1,0 -> RTI.
//  IDLE: req_ready=1. The request is captured on valid&&ready; req_ready drops the same edge.
//  DR_OP: tms 1,0,0 -> Shift-DR; shift {addr,data,op} LSB first (op in bits[1:0]) over DRW TCKs, tms=1 on the last; tms 1,0 -> RTI.
//  RTI_WAIT: IDLE_CYCLES TCKs with tms=0.
//  DR_RES: same scan as DR_OP with op=0, addr/data=0; the shifted-out tdo bits form the result.
//   rsp_op=result[1:0], rsp_data=result[33:2].
//  RESP: rsp_valid=1, rsp_op/rsp_data held stable until rsp_ready; on handshake rsp_valid=0 and FSM -> IDLE.
//  Busy (rsp_op=3) is reported unchanged; no automatic retry or dmireset.
//  Every request (including nop) yields exactly one response, in order; requests are not accepted while a response is pending.
//  Request latency to rsp_valid: (2*(5+DRW)+IDLE_CYCLES)*2*TCK_DIV sysclk cycles + <=2 control cycles.
//  Reset mid-scan: all outputs return to reset values immediately; the full TAP_RST + IR_SCAN is reissued. The in-flight request is dropped with no response.
//  TAP_RST+IR_SCAN run once after reset; the IR is not rescanned per request.
//  req_op=3 is treated as nop.
// TESTING
//  Release reset, TCK_DIV=1 -> trst high for 1 TCK, 5 TCKs tms=1, then tms=0; IR bits on tdi = 1,0,0,0,1; req_ready rises after IR_SCAN.
//  Write op=2 addr=7'h10 data=32'h1 -> first DR_OP tdi bits = 0,1,1,0..0 (data), then addr 0x10 LSB first; tms=1 only on bit DRW-1.
//  TAP model returns {addr,32'hDEADBEEF,2'b00} on the second scan -> rsp_valid with rsp_op=0, rsp_data=32'hDEADBEEF.
//  TAP model returns op=3 -> rsp_op=3, rsp_data=captured data, no further scans until the next request.
//  rsp_ready=0 for 20 cycles -> rsp_valid and rsp_* stable; req_ready=0; tck=0 throughout.
//  Assert sys_reset_n=0 at DR_OP bit 10 -> same cycle tck=0, tms=1, trst=1; after release, full init replays; no response for the dropped request.

Source files
------------

// File: rtl/jtag_dmi_master.sv
// jtag_dmi_master: JTAG host engine that turns DMI requests into TAP IR/DR scans
// and returns the captured status/data on a valid/ready response port.
`timescale 1ns/1ps
module jtag_dmi_master #(
    parameter int              ABITS       = 7,
    parameter int              IRLEN       = 5,
    parameter logic [IRLEN-1:0] IR_DMI     = IRLEN'('h11),
    parameter int              TCK_DIV     = 4,
    parameter int              IDLE_CYCLES = 2
) (
    input  logic             sysclk_i,
    input  logic             sys_reset_n_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [ABITS-1:0] req_addr_i,
    input  logic [31:0]      req_data_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [1:0]       rsp_op_o,
    output logic [31:0]      rsp_data_o,
    output logic             tck_o,
    output logic             tms_o,
    output logic             tdi_o,
    output logic             trst_o,
    input  logic             tdo_i
);
    localparam int DRW = ABITS + 34;

    typedef enum logic [2:0] {TAP_RST, IR_SCAN, IDLE, DR_OP, RTI_WAIT, DR_RES, RESP} state_e;

    state_e         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d, len;
    logic [15:0]    div_q;
    logic [DRW-1:0] dr_q;
    logic           tck_q, tms_q, tdi_q, trst_q, req_ready_q, rsp_valid_q, tdi_d, is_dr;
    logic [1:0]     rsp_op_q;
    logic [31:0]    rsp_data_q;

    // Each state is a fixed list of TCK bits; k is the bit index within the state.
    function automatic logic tms_f(state_e s, logic [7:0] k);
        if (s == TAP_RST) return k < 8'd5;
        if (s == IR_SCAN) return k < 8'd2 || k == 8'(IRLEN + 3) || k == 8'(IRLEN + 4);
        if (s == DR_OP || s == DR_RES) return k == 8'd0 || k == 8'(DRW + 2) || k == 8'(DRW + 3);
        return 1'b0;
    endfunction

    function automatic logic shift_f(state_e s, logic [7:0] k);
        if (s == IR_SCAN) return k >= 8'd4 && k < 8'(IRLEN + 4);
        if (s == DR_OP || s == DR_RES) return k >= 8'd3 && k < 8'(DRW + 3);
        return 1'b0;
    endfunction

    always_comb begin
        len     = state_q == TAP_RST ? 8'd6 : state_q == IR_SCAN ? 8'(IRLEN + 6) :
                  state_q == RTI_WAIT ? 8'(IDLE_CYCLES) : 8'(DRW + 5);
        cnt_d   = cnt_q == len - 8'd1 ? 8'd0 : cnt_q + 8'd1;
        state_d = cnt_q != len - 8'd1 ? state_q : state_q == TAP_RST ? IR_SCAN :
                  state_q == IR_SCAN ? IDLE : state_q == DR_OP && IDLE_CYCLES > 0 ? RTI_WAIT :
                  state_q == DR_RES ? RESP : DR_RES;
        tdi_d   = shift_f(state_d, cnt_d) && (state_d == IR_SCAN ?
                  |(IR_DMI & (IRLEN'(1) << (cnt_d - 8'd4))) : dr_q[0]);
        is_dr   = state_q == DR_OP || state_q == DR_RES;
    end

    always_ff @(posedge sysclk_i or negedge sys_reset_n_i) begin
        if (!sys_reset_n_i) begin
            state_q     <= TAP_RST;
            cnt_q       <= '0;
            div_q       <= '0;
            dr_q        <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            trst_q      <= 1'b1;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_op_q    <= '0;
            rsp_data_q  <= '0;
        end else if (state_q == IDLE) begin
            if (req_valid_i && req_ready_q) begin
                req_ready_q <= 1'b0;
                state_q     <= DR_OP;
                cnt_q       <= '0;
                div_q       <= '0;
                tms_q       <= 1'b1;
                dr_q        <= {req_addr_i, req_data_i, req_op_i == 2'd3 ? 2'd0 : req_op_i};
            end
        end else if (state_q == RESP) begin
            if (rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
                req_ready_q <= 1'b1;
                state_q     <= IDLE;
            end
        end else if (div_q != 16'(TCK_DIV - 1)) begin
            div_q <= div_q + 16'd1;
        end else begin
            div_q <= '0;
            tck_q <= !tck_q;
            // dr_q doubles as tx and rx shift register: tdi leaves bit 0, tdo enters at the top
            if (!tck_q && is_dr && shift_f(state_q, cnt_q)) dr_q <= {tdo_i, dr_q[DRW-1:1]};
            if (tck_q) begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                tms_q   <= tms_f(state_d, cnt_d);
                tdi_q   <= tdi_d;
                trst_q  <= 1'b0;
                if (state_d == IDLE) req_ready_q <= 1'b1;
                if (state_d == DR_RES && state_q != DR_RES) dr_q <= '0;
                if (state_d == RESP) begin
                    rsp_valid_q <= 1'b1;
                    rsp_op_q    <= dr_q[1:0];
                    rsp_data_q  <= dr_q[33:2];
                end
            end
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_op_o    = rsp_op_q;
    assign rsp_data_o  = rsp_data_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;
    assign trst_o      = trst_q;
endmodule

// File: tb/tb_jtag_dmi_master.sv
// tb_jtag_dmi_master: drives jtag_dmi_master against a behavioural IEEE 1149.1 TAP
// with a DMI-style capture register, checking scans and responses.
`timescale 1ns/1ps
module tb_jtag_dmi_master;
    localparam int ABITS = 7, DRW = ABITS + 34, TCK_DIV = 2, IDLEC = 2;
    localparam int NB = 2 * (DRW + 5) + IDLEC, LAT = NB * 2 * TCK_DIV;

    typedef enum logic [3:0] {TLR, RTI, SDRS, CDR, SDR, E1D, PD, E2D, UDR,
                              SIRS, CIR, SIR, E1I, PI, E2I, UIR} tap_e;

    logic sysclk = 0, rst_n = 1, req_valid = 0, rsp_ready = 0, tdo = 0;
    logic req_ready, rsp_valid, tck, tms, tdi, trst;
    logic [1:0] req_op = 0, rsp_op;
    logic [6:0] req_addr = 0;
    logic [31:0] req_data = 0, rsp_data;

    int total = 0, bad = 0, cyc = 0, ntck = 0;
    logic [2:0] blog[$];
    longint tpos[$];
    logic [DRW-1:0] upd[$];
    logic [31:0] tap_data = 32'hDEADBEEF;
    logic [1:0] tap_status = 0;
    logic [DRW-1:0] cap = '0, sr = '0;
    logic [4:0] irsr = 0, ir = 0;
    tap_e ts = TLR;
    logic [33:0] exp_res = '0;

    jtag_dmi_master #(.ABITS(ABITS), .TCK_DIV(TCK_DIV), .IDLE_CYCLES(IDLEC)) dut (
        .sysclk_i(sysclk), .sys_reset_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_op_o(rsp_op), .rsp_data_o(rsp_data),
        .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .trst_o(trst), .tdo_i(tdo)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    always @(posedge tck) begin
        ntck <= ntck + 1;
        blog.push_back({trst, tms, tdi});
        tpos.push_back($time);
    end

    function automatic tap_e nxt(tap_e s, logic m);
        case (s)
            TLR:  return m ? TLR  : RTI;
            RTI:  return m ? SDRS : RTI;
            SDRS: return m ? SIRS : CDR;
            CDR:  return m ? E1D  : SDR;
            SDR:  return m ? E1D  : SDR;
            E1D:  return m ? UDR  : PD;
            PD:   return m ? E2D  : PD;
            E2D:  return m ? UDR  : SDR;
            UDR:  return m ? SDRS : RTI;
            SIRS: return m ? TLR  : CIR;
            CIR:  return m ? E1I  : SIR;
            SIR:  return m ? E1I  : SIR;
            E1I:  return m ? UIR  : PI;
            PI:   return m ? E2I  : PI;
            E2I:  return m ? UIR  : SIR;
            default: return m ? SDRS : RTI;
        endcase
    endfunction

    // TAP plus DMI target: a read/write updates the value captured by the next scan
    always @(posedge tck or posedge trst) begin
        if (trst) begin
            ts <= TLR;
            ir <= '0;
        end else begin
            case (ts)
                CDR: sr <= (ir == 5'h11) ? cap : '0;
                SDR: sr <= {tdi, sr[DRW-1:1]};
                UDR: if (ir == 5'h11) begin
                    upd.push_back(sr);
                    if (sr[1:0] == 2'd1 || sr[1:0] == 2'd2) cap <= {sr[DRW-1:34], tap_data, tap_status};
                end
                CIR: irsr <= 5'b00001;
                SIR: irsr <= {tdi, irsr[4:1]};
                UIR: ir <= irsr;
                default: ;
            endcase
            ts <= nxt(ts, tms);
        end
    end

    always @(negedge tck) tdo <= (ts == SDR) ? sr[0] : 1'b0;

    task automatic send_req(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                            output bit ok, output int c0);
        int n = 0;
        @(negedge sysclk);
        req_valid = 1; req_op = op; req_addr = a; req_data = d;
        while (req_ready !== 1'b1 && n < 3000) begin @(negedge sysclk); n++; end
        ok = (req_ready === 1'b1);
        if (ok) begin @(posedge sysclk); #1; end
        c0 = cyc;
        req_valid = 0;
    endtask

    task automatic collect(input int c0, output bit got, output int lat);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 1000) begin @(negedge sysclk); n++; end
        got = (rsp_valid === 1'b1);
        lat = cyc - c0;
    endtask

    task automatic release_rsp(input int hold);
        repeat (hold) @(negedge sysclk);
        @(negedge sysclk); rsp_ready = 1;
        @(posedge sysclk); #1 rsp_ready = 0;
    endtask

    task automatic test_reset;
        logic [16:0] etms, etdi;
        logic [2:0] e;
        int n = 0, n0;
        #2 rst_n = 0;
        repeat (3) @(negedge sysclk);
        total++; if (tck !== 1'b0) begin bad++; $display("FAIL reset_tck got=%b exp=0", tck); end
        total++; if (tms !== 1'b1) begin bad++; $display("FAIL reset_tms got=%b exp=1", tms); end
        total++; if (tdi !== 1'b0) begin bad++; $display("FAIL reset_tdi got=%b exp=0", tdi); end
        total++; if (trst !== 1'b1) begin bad++; $display("FAIL reset_trst got=%b exp=1", trst); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        total++; if ({rsp_op, rsp_data} !== 34'h0) begin bad++; $display("FAIL reset_rsp got=%h exp=0", {rsp_op, rsp_data}); end
        blog.delete(); tpos.delete();
        rst_n = 1;
        while (req_ready !== 1'b1 && n < 2000) begin @(negedge sysclk); n++; end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL init_ready got=%b exp=1", req_ready); end
        total++; if (blog.size() != 17) begin bad++; $display("FAIL init_len got=%0d exp=17", blog.size()); end
        etms = 17'b11111011000000110;
        etdi = 17'b00000000001000100;
        for (int i = 0; i < 17 && i < blog.size(); i++) begin
            e = {i == 0, etms[16-i], etdi[16-i]};
            total++; if (blog[i] !== e) begin bad++; $display("FAIL init_bit%0d trst_tms_tdi got=%b exp=%b", i, blog[i], e); end
        end
        total++; if (ir !== 5'h11) begin bad++; $display("FAIL init_ir got=%h exp=11", ir); end
        total++; if (ts !== RTI) begin bad++; $display("FAIL init_tap_state got=%0d exp=%0d", ts, RTI); end
        total++;
        if (tpos.size() < 2 || tpos[1] - tpos[0] != 20 * TCK_DIV) begin
            bad++; $display("FAIL tck_period got=%0d exp=%0d", tpos.size() < 2 ? 0 : tpos[1] - tpos[0], 20 * TCK_DIV);
        end
        n0 = ntck;
        repeat (30) @(negedge sysclk);
        total++; if (ntck != n0 || tck !== 1'b0) begin bad++; $display("FAIL idle_tck edges=%0d tck=%b exp 0 0", ntck - n0, tck); end
    endtask

    task automatic test_write;
        logic [DRW-1:0] ev;
        bit ok, got;
        int c0, lat, n0, miss = 0;
        ev = {7'h10, 32'h1, 2'b10};
        tap_data = 32'hDEADBEEF; tap_status = 0;
        upd.delete(); blog.delete(); n0 = ntck;
        send_req(2'd2, 7'h10, 32'h1, ok, c0);
        collect(c0, got, lat);
        total++; if (!ok || !got) begin bad++; $display("FAIL wr_handshake accepted=%0d responded=%0d exp 1 1", ok, got); end
        total++; if (lat < LAT || lat > LAT + 2) begin bad++; $display("FAIL wr_latency got=%0d exp=%0d..%0d", lat, LAT, LAT + 2); end
        total++; if (rsp_op !== 2'd0) begin bad++; $display("FAIL wr_rsp_op got=%0d exp=0", rsp_op); end
        total++; if (rsp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rsp_data got=%h exp=deadbeef", rsp_data); end
        release_rsp(0);
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL wr_release valid=%b ready=%b exp 0 1", rsp_valid, req_ready); end
        total++;
        if (upd.size() != 2) begin bad++; $display("FAIL wr_updates got=%0d exp=2", upd.size()); end
        else if (upd[0] !== ev || upd[1] !== '0) begin bad++; $display("FAIL wr_dr got=%h,%h exp=%h,0", upd[0], upd[1], ev); end
        if (blog.size() > DRW + 2)
            for (int k = 3; k < DRW + 3; k++)
                if (blog[k][1] !== (k == DRW + 2) || blog[k][0] !== ev[k-3]) miss++;
        total++; if (blog.size() <= DRW + 2 || miss != 0) begin bad++; $display("FAIL wr_shift_bits bad_bits=%0d exp=0", miss); end
        total++; if (ntck - n0 != NB) begin bad++; $display("FAIL wr_tck_count got=%0d exp=%0d", ntck - n0, NB); end
        total++; if (ts !== RTI) begin bad++; $display("FAIL wr_tap_state got=%0d exp=%0d", ts, RTI); end
        exp_res = {32'hDEADBEEF, 2'b00};
    endtask

    task automatic test_busy;
        bit ok, got;
        int c0, lat, n0;
        tap_data = $urandom; tap_status = 2'd3;
        send_req(2'd1, 7'($urandom), 32'h0, ok, c0);
        collect(c0, got, lat);
        exp_res = {tap_data, 2'd3};
        total++; if (!got || {rsp_data, rsp_op} !== exp_res) begin bad++; $display("FAIL busy_rsp got=%h exp=%h", {rsp_data, rsp_op}, exp_res); end
        release_rsp(1);
        n0 = ntck;
        repeat (60) @(negedge sysclk);
        total++; if (ntck != n0 || tck !== 1'b0) begin bad++; $display("FAIL busy_no_retry edges=%0d exp=0", ntck - n0); end
    endtask

    task automatic test_backpressure;
        bit ok, got;
        int c0, lat;
        logic [1:0] sop;
        logic [31:0] sdat;
        tap_data = $urandom; tap_status = 2'd0;
        send_req(2'd2, 7'($urandom), $urandom, ok, c0);
        collect(c0, got, lat);
        exp_res = {tap_data, 2'd0};
        sop = rsp_op; sdat = rsp_data;
        total++; if (!got || {sdat, sop} !== exp_res) begin bad++; $display("FAIL bp_rsp got=%h exp=%h", {sdat, sop}, exp_res); end
        for (int i = 0; i < 20; i++) begin
            @(negedge sysclk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_op !== sop || rsp_data !== sdat || req_ready !== 1'b0 || tck !== 1'b0) begin
                bad++; $display("FAIL bp_hold cyc%0d valid=%b op=%0d data=%h ready=%b tck=%b exp 1 %0d %h 0 0",
                                i, rsp_valid, rsp_op, rsp_data, req_ready, tck, sop, sdat);
            end
        end
        release_rsp(0);
    endtask

    task automatic test_back_to_back;
        bit ok, got;
        int c0, lat, s;
        logic [1:0] op, eop;
        logic [6:0] a;
        logic [31:0] d;
        logic [DRW-1:0] ev;
        for (int it = 0; it < 12; it++) begin
            op = 2'($urandom_range(0, 3)); a = 7'($urandom); d = $urandom;
            s = $urandom_range(0, 2);
            tap_data = $urandom; tap_status = s == 0 ? 2'd0 : s == 1 ? 2'd2 : 2'd3;
            eop = op == 2'd3 ? 2'd0 : op;
            ev = {a, d, eop};
            if (eop != 2'd0) exp_res = {tap_data, tap_status};
            upd.delete();
            send_req(op, a, d, ok, c0);
            collect(c0, got, lat);
            total++; if (!got || {rsp_data, rsp_op} !== exp_res) begin bad++; $display("FAIL b2b%0d_rsp op=%0d got=%h exp=%h", it, op, {rsp_data, rsp_op}, exp_res); end
            total++; if (lat < LAT || lat > LAT + 2) begin bad++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", it, lat, LAT); end
            release_rsp($urandom_range(0, 3));
            total++;
            if (upd.size() != 2) begin bad++; $display("FAIL b2b%0d_updates got=%0d exp=2", it, upd.size()); end
            else if (upd[0] !== ev || upd[1] !== '0) begin bad++; $display("FAIL b2b%0d_dr got=%h,%h exp=%h,0", it, upd[0], upd[1], ev); end
        end
    endtask

    task automatic test_reset_mid;
        bit ok, got, seen = 0;
        int c0, lat, n0, n = 0;
        upd.delete();
        send_req(2'd2, 7'h22, $urandom, ok, c0);
        n0 = ntck - 0;
        while (ntck - n0 < 14 && n < 500) begin @(negedge sysclk); n++; end
        total++; if (ntck - n0 < 14) begin bad++; $display("FAIL mid_reach_bit10 edges=%0d exp=14", ntck - n0); end
        rst_n = 0;
        #1;
        total++; if (tck !== 1'b0 || tms !== 1'b1 || trst !== 1'b1 || tdi !== 1'b0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL mid_async tck=%b tms=%b trst=%b tdi=%b ready=%b exp 0 1 1 0 0", tck, tms, trst, tdi, req_ready);
        end
        repeat (3) @(negedge sysclk);
        blog.delete();
        rst_n = 1;
        n = 0;
        while (req_ready !== 1'b1 && n < 2000) begin
            @(negedge sysclk); n++;
            if (rsp_valid === 1'b1) seen = 1;
        end
        total++; if (seen) begin bad++; $display("FAIL mid_dropped_rsp got=1 exp=0"); end
        total++; if (blog.size() != 17 || blog[0][2] !== 1'b1) begin bad++; $display("FAIL mid_reinit len=%0d exp=17", blog.size()); end
        total++; if (ir !== 5'h11 || ts !== RTI) begin bad++; $display("FAIL mid_reinit_tap ir=%h state=%0d exp 11 %0d", ir, ts, RTI); end
        total++; if (upd.size() != 0) begin bad++; $display("FAIL mid_no_update got=%0d exp=0", upd.size()); end
        tap_data = $urandom; tap_status = 2'd0;
        send_req(2'd1, 7'h05, 32'h0, ok, c0);
        collect(c0, got, lat);
        exp_res = {tap_data, 2'd0};
        total++; if (!got || {rsp_data, rsp_op} !== exp_res) begin bad++; $display("FAIL mid_after_rsp got=%h exp=%h", {rsp_data, rsp_op}, exp_res); end
        release_rsp(0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_busy();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
